sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock parametrised FIFO, successor to the dual-clock FIFO memory/pointer set.
//  Used where producer and consumer share one clock, so no gray-code pointer synchroniser is needed.
//  Adds occupancy count, programmable almost-full/almost-empty flags, error pulses and a
//  selectable read mode: standard (registered rdata) or first-word-fall-through (FWFT).
// PARAMETERS
//  DSIZE      8   data width in bits
//  ASIZE      4   address width; DEPTH = 1<<ASIZE entries
//  FWFT       0   0 = standard read mode; 1 = first-word-fall-through
//  AFULL_TH   14  afull asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH  2   aempty asserted when count <= AEMPTY_TH (0..DEPTH-1)
// PORTS
//  clk     in   1        single clock, all logic on posedge
//  rst     in   1        reset: synchronous, active-high
//  wen     in   1        write request
//  wdata   in   DSIZE    write data
//  ren     in   1        read request (standard: fetch; FWFT: pop/acknowledge head)
//  rdata   out  DSIZE    read data
//  rvalid  out  1        rdata holds a valid popped/head word
//  full    out  1        count == DEPTH
//  empty   out  1        count == 0
//  afull   out  1        count >= AFULL_TH
//  aempty  out  1        count <= AEMPTY_TH
//  count   out  ASIZE+1  current occupancy, 0..DEPTH
//  ovf     out  1        1-cycle pulse: write rejected
//  udf     out  1        1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wptr=rptr=0, count=0, empty=1, aempty=1, full=0, afull=0,
//    rvalid=0, rdata=0, ovf=0, udf=0. Memory contents are not cleared. Reset wins over wen/ren.
//  - Pointers are ASIZE+1 bits and wrap naturally. full when MSBs differ and the lower bits match;
//    empty when the pointers are equal. count = wptr - rptr (mod 2^(ASIZE+1)).
//  - Write accept: wa = wen & (!full | ra). Writing into a full FIFO is allowed only
//    when a read is accepted in the same cycle.
//  - Read accept: ra = ren & !empty. A read from an empty FIFO is never accepted, even with a
//    simultaneous write; the written word becomes readable on the next cycle.
//  - Rejected wen -> ovf=1 on the next cycle, no state change. Rejected ren -> udf=1 on the next cycle.
//  - wa & ra together: count unchanged, both pointers advance. Flags are all registered and
//    updated from the next-state count in the same edge.
//  - Standard mode (FWFT=0): on ra, rdata <= mem[rptr] and rvalid=1 on the next cycle
//    (1-cycle latency). rvalid=0 in cycles without ra. rdata holds its last value otherwise.
//  - FWFT mode (FWFT=1): rdata = mem[rptr] combinationally and rvalid = !empty. The head word is
//    visible 1 cycle after its write edge. ren acts as pop; after a pop the next word appears
//    in the same cycle that the pointer advances.
//  - Memory write uses the write-port address wptr[ASIZE-1:0]. Read-during-write to the same
//    entry cannot occur: that entry is either empty or has already been popped.
//  - Thresholds are checked at elaboration. Out-of-range AFULL_TH/AEMPTY_TH is an $error.
// STRUCTURE
//  - Shared header fifo_defs.vh: `FIFO_MODE_STD=0, `FIFO_MODE_FWFT=1, and the pointer-compare
//    macros common to the async and sync FIFOs.
//  - One sub-module: sync_fifo_mem (DSIZE x DEPTH register array, registered write, combinational
//    read). Keeps the `VENDORRAM substitution point.
//  - Top level holds the pointers, the count/flag registers, the error pulses and the
//    mode-dependent read path (generate on FWFT).
// TESTING
//  1 Reset mid-traffic: write 5, assert rst 1 cycle -> count=0, empty=1, aempty=1, rvalid=0, ovf=udf=0.
//  2 Fill, DSIZE=8 ASIZE=4: write 0x00..0x0F -> full=1, count=16, afull from count 14.
//    A 17th wen alone -> ovf pulse, count stays 16.
//  3 Drain, standard mode: 16 reads -> rdata 0x00..0x0F each 1 cycle after ren, with rvalid.
//    A 17th ren -> udf pulse, empty=1.
//  4 Full with wen&ren same cycle -> both accepted, count stays 16, new word read back after 15 pops.
//  5 Empty with wen&ren same cycle -> write accepted, read rejected (udf pulse), count=1.
//  6 FWFT=1: write 0xA5 -> rdata=0xA5 and rvalid=1 the next cycle with no ren. Pop -> empty=1.
//    Pointer wrap across 3 full laps keeps the data order.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//  Shared definitions for the single-clock FIFO:
//   - read-mode selector constants (standard registered read / FWFT)
//   - the status flag bundle carried as one registered struct
//   - pointer-compare helpers also used by the dual-clock FIFO.
//     They work on wrap-bit pointers: one extra MSB above the address bits.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam bit FIFO_MODE_STD  = 1'b0;
   localparam bit FIFO_MODE_FWFT = 1'b1;

   // Pointers of any width are zero-extended to this width before comparing
   localparam int PTR_MAX_W = 32;
   typedef logic [PTR_MAX_W-1:0] ptr_max_t;

   // Registered status flags, all derived from the next-state occupancy
   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } fifo_flags_t;

   // Pointers equal (including the wrap bit) -> nothing stored
   function automatic logic ptr_empty(input ptr_max_t wp, input ptr_max_t rp);
      return (wp == rp);
   endfunction

   // Address bits equal but wrap bits differ -> writer is one lap ahead
   function automatic logic ptr_full(input ptr_max_t wp, input ptr_max_t rp, input int asize);
      ptr_max_t diff;
      ptr_max_t low_mask;
      ptr_max_t wrap_bit;
      diff     = wp ^ rp;
      wrap_bit = ptr_max_t'(1) << asize;
      low_mask = wrap_bit - ptr_max_t'(1);
      return ((diff & low_mask) == ptr_max_t'(0)) && ((diff & wrap_bit) != ptr_max_t'(0));
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//  DSIZE x DEPTH storage for the single-clock FIFO. Registered write,
//  combinational (asynchronous) read. Contents are never reset.
//  Defining VENDORRAM swaps in a vendor dual-port macro with the same ports.
// Ports
//  clk_i     clock
//  we_i      write enable (already qualified by the accept logic)
//  waddr_i   write address
//  wdata_i   write data
//  raddr_i   read address
//  rdata_o   read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [ASIZE-1:0] raddr_i,
   output logic [DSIZE-1:0] rdata_o
);

   localparam int DEPTH = 1 << ASIZE;

`ifdef VENDORRAM
   vendor_ram_dp #(
      .DATA_W (DSIZE),
      .ADDR_W (ASIZE)
   ) u_vendor_ram (
      .clk   (clk_i),
      .we    (we_i),
      .waddr (waddr_i),
      .wdata (wdata_i),
      .raddr (raddr_i),
      .rdata (rdata_o)
   );
`else
   logic [DSIZE-1:0] mem_q [DEPTH];

   // Write port: store on accepted write
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Same-entry read-during-write cannot happen, so no bypass is needed
   assign rdata_o = mem_q[raddr_i];
`endif

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//  Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
//  overflow/underflow pulses and selectable read mode.
// Ports
//  clk     clock, all logic on posedge
//  rst     synchronous active-high reset (wins over wen/ren)
//  wen     write request          wdata  write data
//  ren     read request (standard: fetch; FWFT: pop head)
//  rdata   read data              rvalid rdata holds a valid word
//  full    count == DEPTH         empty  count == 0
//  afull   count >= AFULL_TH      aempty count <= AEMPTY_TH
//  count   occupancy 0..DEPTH
//  ovf     1-cycle pulse, write rejected
//  udf     1-cycle pulse, read rejected
// -----------------------------------------------------------------------------
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter bit FWFT      = FIFO_MODE_STD,
   parameter int AFULL_TH  = 14,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [DSIZE-1:0] wdata,
   input  logic             ren,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   output logic             full,
   output logic             empty,
   output logic             afull,
   output logic             aempty,
   output logic [ASIZE:0]   count,
   output logic             ovf,
   output logic             udf
);

   localparam int             DEPTH    = 1 << ASIZE;
   localparam int             PW       = ASIZE + 1;
   localparam logic [ASIZE:0] AFULL_C  = PW'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_C = PW'(AEMPTY_TH);

   // Threshold range checks at elaboration
   if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_afull_range_err
      $error("sync_fifo: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
   end
   if ((AEMPTY_TH < 0) || (AEMPTY_TH > (DEPTH - 1))) begin : g_aempty_range_err
      $error("sync_fifo: AEMPTY_TH=%0d outside 0..%0d", AEMPTY_TH, DEPTH - 1);
   end

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic [ASIZE:0]   count_q, count_d;
   fifo_flags_t      flags_q, flags_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             ra_s;
   logic             wa_s;
   logic [DSIZE-1:0] mem_rdata_s;

   // Accept decisions, next pointers, next count and flags
   always_comb begin
      // A read is never accepted from an empty FIFO, even with a same-cycle write
      ra_s = ren & ~flags_q.empty;
      // A full FIFO can take a write only when a read frees a slot this cycle
      wa_s = wen & (~flags_q.full | ra_s);

      wptr_d = wptr_q;
      if (wa_s) begin
         wptr_d = wptr_q + PW'(1);
      end else begin
         wptr_d = wptr_q;
      end

      rptr_d = rptr_q;
      if (ra_s) begin
         rptr_d = rptr_q + PW'(1);
      end else begin
         rptr_d = rptr_q;
      end

      // Modular difference of wrap-bit pointers gives 0..DEPTH
      count_d        = wptr_d - rptr_d;
      flags_d.full   = ptr_full(ptr_max_t'(wptr_d), ptr_max_t'(rptr_d), ASIZE);
      flags_d.empty  = ptr_empty(ptr_max_t'(wptr_d), ptr_max_t'(rptr_d));
      flags_d.afull  = (count_d >= AFULL_C);
      flags_d.aempty = (count_d <= AEMPTY_C);

      ovf_d = wen & ~wa_s;
      udf_d = ren & ~ra_s;
   end

   // Pointer, occupancy, flag and error-pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q         <= '0;
         rptr_q         <= '0;
         count_q        <= '0;
         flags_q.full   <= 1'b0;
         flags_q.empty  <= 1'b1;
         flags_q.afull  <= 1'b0;
         flags_q.aempty <= 1'b1;
         ovf_q          <= 1'b0;
         udf_q          <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   sync_fifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (wa_s),
      .waddr_i (wptr_q[ASIZE-1:0]),
      .wdata_i (wdata),
      .raddr_i (rptr_q[ASIZE-1:0]),
      .rdata_o (mem_rdata_s)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      logic [DSIZE-1:0] rdata_s;

      // Head word shown directly; zero while empty so reset reads back 0
      always_comb begin
         rdata_s = '0;
         if (~flags_q.empty) begin
            rdata_s = mem_rdata_s;
         end else begin
            rdata_s = '0;
         end
      end

      assign rdata  = rdata_s;
      assign rvalid = ~flags_q.empty;
   end else begin : g_std
      logic [DSIZE-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      // Capture the head on an accepted read, otherwise hold
      always_comb begin
         rvalid_d = ra_s;
         rdata_d  = rdata_q;
         if (ra_s) begin
            rdata_d = mem_rdata_s;
         end else begin
            rdata_d = rdata_q;
         end
      end

      // Registered read data and its valid strobe
      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

   assign full   = flags_q.full;
   assign empty  = flags_q.empty;
   assign afull  = flags_q.afull;
   assign aempty = flags_q.aempty;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//  Directed bench: one standard-mode and one FWFT instance share the inputs.
//  Steps 1-5 check the standard instance, step 6 the FWFT instance.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

   logic       clk;
   logic       rst;
   logic       wen;
   logic       ren;
   logic [7:0] wdata;

   logic [7:0] s_rdata, f_rdata;
   logic       s_rvalid, f_rvalid;
   logic       s_full, f_full, s_empty, f_empty;
   logic       s_afull, f_afull, s_aempty, f_aempty;
   logic [4:0] s_count, f_count;
   logic       s_ovf, f_ovf, s_udf, f_udf;

   int total  = 0;
   int passed = 0;

   sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(1'b0), .AFULL_TH(14), .AEMPTY_TH(2)) u_std (
      .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full), .empty(s_empty),
      .afull(s_afull), .aempty(s_aempty), .count(s_count), .ovf(s_ovf), .udf(s_udf)
   );

   sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(1'b1), .AFULL_TH(14), .AEMPTY_TH(2)) u_fwft (
      .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
      .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full), .empty(f_empty),
      .afull(f_afull), .aempty(f_aempty), .count(f_count), .ovf(f_ovf), .udf(f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   initial begin
      logic [7:0] exp_d;

      rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
      step();
      step();
      chk("rst_count",  32'(s_count),  32'd0);
      chk("rst_empty",  32'(s_empty),  32'd1);
      chk("rst_aempty", 32'(s_aempty), 32'd1);
      chk("rst_full",   32'(s_full),   32'd0);
      chk("rst_afull",  32'(s_afull),  32'd0);
      chk("rst_rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_rdata",  32'(s_rdata),  32'd0);
      chk("rst_ovf",    32'(s_ovf),    32'd0);
      chk("rst_udf",    32'(s_udf),    32'd0);
      rst = 1'b0;

      // 1: reset mid-traffic, reset wins over wen/ren
      wen = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wdata = 8'(i + 1);
         step();
      end
      chk("t1_count5", 32'(s_count), 32'd5);
      rst = 1'b1; ren = 1'b1;
      step();
      chk("t1_count",  32'(s_count),  32'd0);
      chk("t1_empty",  32'(s_empty),  32'd1);
      chk("t1_aempty", 32'(s_aempty), 32'd1);
      chk("t1_rvalid", 32'(s_rvalid), 32'd0);
      chk("t1_ovf",    32'(s_ovf),    32'd0);
      chk("t1_udf",    32'(s_udf),    32'd0);
      rst = 1'b0; wen = 1'b0; ren = 1'b0;

      // 2: fill 0x00..0x0F, then rejected 17th write
      wen = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wdata = 8'(i);
         step();
         chk("t2_count",  32'(s_count),  32'(i + 1));
         chk("t2_afull",  32'(s_afull),  ((i + 1) >= 14) ? 32'd1 : 32'd0);
         chk("t2_aempty", 32'(s_aempty), ((i + 1) <= 2)  ? 32'd1 : 32'd0);
         chk("t2_full",   32'(s_full),   (i == 15)       ? 32'd1 : 32'd0);
      end
      wdata = 8'hEE;
      step();
      chk("t2_ovf",     32'(s_ovf),   32'd1);
      chk("t2_count16", 32'(s_count), 32'd16);
      chk("t2_full16",  32'(s_full),  32'd1);
      wen = 1'b0;
      step();
      chk("t2_ovf_clr", 32'(s_ovf),   32'd0);
      chk("t2_hold16",  32'(s_count), 32'd16);

      // 3: drain in standard mode, then rejected 17th read
      ren = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("t3_rvalid", 32'(s_rvalid), 32'd1);
         chk("t3_rdata",  32'(s_rdata),  32'(i));
         chk("t3_count",  32'(s_count),  32'(15 - i));
      end
      step();
      chk("t3_udf",    32'(s_udf),    32'd1);
      chk("t3_rvalid0",32'(s_rvalid), 32'd0);
      chk("t3_empty",  32'(s_empty),  32'd1);
      chk("t3_hold",   32'(s_rdata),  32'h0F);
      ren = 1'b0;
      step();
      chk("t3_udf_clr", 32'(s_udf), 32'd0);

      // 4: full with simultaneous write and read
      wen = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wdata = 8'(8'h20 + i);
         step();
      end
      ren = 1'b1; wdata = 8'h99;
      step();
      chk("t4_count", 32'(s_count),  32'd16);
      chk("t4_full",  32'(s_full),   32'd1);
      chk("t4_ovf",   32'(s_ovf),    32'd0);
      chk("t4_udf",   32'(s_udf),    32'd0);
      chk("t4_rd0",   32'(s_rdata),  32'h20);
      chk("t4_rv0",   32'(s_rvalid), 32'd1);
      wen = 1'b0;
      for (int i = 1; i < 16; i++) begin
         step();
         chk("t4_rdata", 32'(s_rdata), 32'(8'h20 + i));
      end
      step();
      chk("t4_newword", 32'(s_rdata), 32'h99);
      chk("t4_empty",   32'(s_empty), 32'd1);
      chk("t4_count0",  32'(s_count), 32'd0);
      ren = 1'b0;

      // 5: empty with simultaneous write and read
      wen = 1'b1; ren = 1'b1; wdata = 8'h5A;
      step();
      chk("t5_udf",    32'(s_udf),    32'd1);
      chk("t5_ovf",    32'(s_ovf),    32'd0);
      chk("t5_count",  32'(s_count),  32'd1);
      chk("t5_rvalid", 32'(s_rvalid), 32'd0);
      chk("t5_empty",  32'(s_empty),  32'd0);
      wen = 1'b0;
      step();
      chk("t5_rdata",  32'(s_rdata),  32'h5A);
      chk("t5_rv",     32'(s_rvalid), 32'd1);
      chk("t5_count0", 32'(s_count),  32'd0);
      chk("t5_udf0",   32'(s_udf),    32'd0);
      ren = 1'b0;
      step();
      chk("t5_rv_low", 32'(s_rvalid), 32'd0);
      chk("t5_hold",   32'(s_rdata),  32'h5A);

      // 6: FWFT instance
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_rst_rv",    32'(f_rvalid), 32'd0);
      chk("t6_rst_rdata", 32'(f_rdata),  32'd0);
      chk("t6_rst_empty", 32'(f_empty),  32'd1);
      wen = 1'b1; wdata = 8'hA5;
      step();
      wen = 1'b0;
      chk("t6_head",  32'(f_rdata),  32'hA5);
      chk("t6_rv",    32'(f_rvalid), 32'd1);
      chk("t6_count", 32'(f_count),  32'd1);
      ren = 1'b1;
      step();
      ren = 1'b0;
      chk("t6_empty", 32'(f_empty),  32'd1);
      chk("t6_rv0",   32'(f_rvalid), 32'd0);

      for (int lap = 0; lap < 3; lap++) begin
         wen = 1'b1;
         for (int i = 0; i < 16; i++) begin
            wdata = 8'((lap * 16 + i) * 7 + 3);
            step();
         end
         wen = 1'b0;
         chk("t6_full", 32'(f_full), 32'd1);
         for (int i = 0; i < 16; i++) begin
            exp_d = 8'((lap * 16 + i) * 7 + 3);
            chk("t6_lap_rdata", 32'(f_rdata),  32'(exp_d));
            chk("t6_lap_rv",    32'(f_rvalid), 32'd1);
            ren = 1'b1;
            step();
         end
         ren = 1'b0;
         chk("t6_lap_empty", 32'(f_empty), 32'd1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
